// File: rtl/d_mem_responder.sv
// d_mem_responder: word memory behind a valid/ready request/response pair.
// Each request is answered a fixed LATENCY edges after acceptance, with error reporting.
module d_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  err_count
);
  // state | meaning
  // IDLE  | ready to accept a request
  // WAIT  | latency down-counter running toward terminal count
  // RESP  | response held until resp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int AW = $clog2(DEPTH);

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          lat_write;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic          accept;
  logic          resp_entry;
  logic          req_bad;
  logic          do_store;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem [DEPTH];

  assign req_bad  = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(DEPTH));
  assign word_idx = lat_addr[AW+1:2];
  assign do_store = resp_entry && lat_write && !req_bad;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    resp_entry = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          cnt_nxt   = 4'(LATENCY - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          resp_entry = 1'b1;
          state_nxt  = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (resp_entry) begin
        resp_err   <= req_bad;
        resp_rdata <= (req_bad || lat_write) ? 32'd0 : mem[word_idx];
        if (req_bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

  // Memory is deliberately unreset; gating on reset keeps an aborted store from landing.
  always_ff @(posedge clock) begin
    if (reset && do_store) mem[word_idx] <= lat_wdata;
  end

endmodule

// File: tb/tb_d_mem_responder.sv
// Self-checking bench for d_mem_responder: directed scenarios plus randomized traffic
// against a plain array/counter model; extra instances cover LATENCY=1 and LATENCY=15.
module tb_d_mem_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  err_count;

  logic        lb_req_valid = 1'b0, lb_req_write = 1'b0, lb_resp_ready = 1'b1;
  logic [31:0] lb_req_addr = '0, lb_req_wdata = '0;
  logic        l1_req_ready, l1_resp_valid, l1_resp_err;
  logic [31:0] l1_resp_rdata;
  logic [7:0]  l1_err_count;
  logic        l15_req_ready, l15_resp_valid, l15_resp_err;
  logic [31:0] l15_resp_rdata;
  logic [7:0]  l15_err_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [16];
  int mdl_errs = 0;

  always #5 clock = ~clock;

  d_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .err_count(err_count));

  d_mem_responder #(.DEPTH(256), .LATENCY(1)) dut_l1 (
    .clock(clock), .reset(reset), .req_valid(lb_req_valid), .req_ready(l1_req_ready),
    .req_write(lb_req_write), .req_addr(lb_req_addr), .req_wdata(lb_req_wdata),
    .resp_valid(l1_resp_valid), .resp_ready(lb_resp_ready), .resp_rdata(l1_resp_rdata),
    .resp_err(l1_resp_err), .err_count(l1_err_count));

  d_mem_responder #(.DEPTH(256), .LATENCY(15)) dut_l15 (
    .clock(clock), .reset(reset), .req_valid(lb_req_valid), .req_ready(l15_req_ready),
    .req_write(lb_req_write), .req_addr(lb_req_addr), .req_wdata(lb_req_wdata),
    .resp_valid(l15_resp_valid), .resp_ready(lb_resp_ready), .resp_rdata(l15_resp_rdata),
    .resp_err(l15_resp_err), .err_count(l15_err_count));

  task automatic apply_reset;
    @(negedge clock);
    reset = 1'b0; req_valid = 1'b0; lb_req_valid = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    mdl_errs = 0;
  endtask

  // One complete transaction on the main instance; lat counts edges from acceptance to resp_valid.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout req_ready got %0b exp 1", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (!resp_valid && lat < 40) begin @(posedge clock); #1; lat++; end
    rd = resp_rdata; er = resp_err;
    @(negedge clock); resp_ready = 1'b1;
    @(posedge clock); #1; resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b exp 0", resp_valid); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %08h exp 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", resp_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    checks++; if (l1_req_ready !== 1'b1 || l15_req_ready !== 1'b1) begin errors++; $display("FAIL reset_lb_ready got %0b/%0b exp 1/1", l1_req_ready, l15_req_ready); end
    checks++; if (l1_err_count !== 8'd0 || l15_err_count !== 8'd0) begin errors++; $display("FAIL reset_lb_err_count got %0d/%0d exp 0/0", l1_err_count, l15_err_count); end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat;
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency got %0d exp 2", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL store_resp got err=%0b rdata=%08h exp err=0 rdata=0", er, rd); end
    run_txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency got %0d exp 2", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_resp got err=%0b rdata=%08h exp err=0 rdata=deadbeef", er, rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    run_txn(1'b1, 32'h0, 32'hA5A55A5A, rd, er, lat);
    run_txn(1'b0, 32'h13, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL misaligned_resp got err=%0b rdata=%08h exp err=1 rdata=0", er, rd); end
    run_txn(1'b1, 32'h400, 32'h11112222, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL out_of_range_resp got err=%0b rdata=%08h exp err=1 rdata=0", er, rd); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL err_count_two got %0d exp 2", err_count); end
    run_txn(1'b0, 32'h0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'hA5A55A5A) begin errors++; $display("FAIL mem_unmodified got err=%0b rdata=%08h exp err=0 rdata=a5a55a5a", er, rd); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic er; int lat; int n;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = '0; resp_ready = 1'b0;
    @(posedge clock); #1;
    n = 0;
    while (!resp_valid && n < 40) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = $urandom;
      @(posedge clock); #1; n++;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL bp_latency got %0d exp 2", n); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      req_valid = 1'($urandom); req_write = 1'b1; req_addr = 32'($urandom_range(0, 7)) << 2;
      req_wdata = $urandom; resp_ready = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%0b ready=%0b rdata=%08h err=%0b exp 1 0 deadbeef 0", i, resp_valid, req_ready, resp_rdata, resp_err);
      end
    end
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; resp_ready = 1'b1;
    @(posedge clock); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got valid=%0b ready=%0b exp 0 1", resp_valid, req_ready); end
    req_valid = 1'b0; resp_ready = 1'b0;
    run_txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL bp_no_write got rdata=%08h err=%0b exp deadbeef 0", rd, er); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat; int n;
    run_txn(1'b1, 32'h20, 32'h0BADF00D, rd, er, lat);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clock); #1; req_valid = 1'b0;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_in_wait got ready=%0b valid=%0b rdata=%08h err=%0b cnt=%0d exp 1 0 0 0 0", req_ready, resp_valid, resp_rdata, resp_err, err_count);
    end
    @(negedge clock); reset = 1'b1;
    run_txn(1'b0, 32'h20, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin errors++; $display("FAIL aborted_store got rdata=%08h err=%0b exp 0badf00d 0", rd, er); end
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; resp_ready = 1'b0;
    @(posedge clock); #1; req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clock); #1; n++; end
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL pre_reset_resp got valid=%0b rdata=%08h exp 1 0badf00d", resp_valid, resp_rdata); end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_in_resp got valid=%0b ready=%0b rdata=%08h exp 0 1 0", resp_valid, req_ready, resp_rdata);
    end
    @(negedge clock); reset = 1'b1;
    mdl_errs = 0;
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d, exp_rd; logic er, w, bad; int lat, kind, idx;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      run_txn(1'b1, 32'(i) << 2, mdl[i], rd, er, lat);
    end
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 6)      a = 32'($urandom_range(0, 15)) << 2;
      else if (kind < 8) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else               a = (32'd256 + 32'($urandom_range(0, 15))) << 2;
      w = 1'($urandom); d = $urandom;
      bad = (a % 4 != 0) || (a / 4 >= 256);
      idx = int'(a / 4);
      exp_rd = (bad || w) ? 32'd0 : mdl[idx];
      if (!bad && w) mdl[idx] = d;
      if (bad && mdl_errs < 255) mdl_errs++;
      run_txn(w, a, d, rd, er, lat);
      checks++;
      if (lat !== 2 || er !== bad || rd !== exp_rd || err_count !== 8'(mdl_errs)) begin
        errors++;
        $display("FAIL random_txn %0d addr=%08h w=%0b got lat=%0d err=%0b rdata=%08h cnt=%0d exp 2 %0b %08h %0d", t, a, w, lat, er, rd, err_count, bad, exp_rd, mdl_errs);
      end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] rd, a; logic er; int lat;
    apply_reset();
    for (int i = 0; i < 260; i++) begin
      a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      run_txn(1'($urandom), a, $urandom, rd, er, lat);
      if (mdl_errs < 255) mdl_errs++;
      checks++;
      if (err_count !== 8'(mdl_errs) || er !== 1'b1) begin
        errors++;
        $display("FAIL saturation req %0d got cnt=%0d err=%0b exp %0d 1", i, err_count, er, mdl_errs);
      end
    end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL saturation_final got %0d exp 255", err_count); end
  endtask

  task automatic lb_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int l1, output int l15, output logic [31:0] rd1, output logic [31:0] rd15,
                        output logic e1, output logic e15);
    @(negedge clock);
    lb_req_valid = 1'b1; lb_req_write = w; lb_req_addr = a; lb_req_wdata = d; lb_resp_ready = 1'b1;
    @(posedge clock); #1; lb_req_valid = 1'b0;
    l1 = 0; l15 = 0; rd1 = '0; rd15 = '0; e1 = 1'b0; e15 = 1'b0;
    for (int k = 1; k <= 30 && (l1 == 0 || l15 == 0); k++) begin
      @(posedge clock); #1;
      if (l1_resp_valid && l1 == 0) begin l1 = k; rd1 = l1_resp_rdata; e1 = l1_resp_err; end
      if (l15_resp_valid && l15 == 0) begin l15 = k; rd15 = l15_resp_rdata; e15 = l15_resp_err; end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_latency_builds;
    int l1, l15; logic [31:0] rd1, rd15; logic e1, e15;
    apply_reset();
    lb_txn(1'b1, 32'h8, 32'hCAFEF00D, l1, l15, rd1, rd15, e1, e15);
    checks++; if (l1 !== 1) begin errors++; $display("FAIL lat1_store got %0d exp 1", l1); end
    checks++; if (l15 !== 15) begin errors++; $display("FAIL lat15_store got %0d exp 15", l15); end
    lb_txn(1'b0, 32'h8, 32'h0, l1, l15, rd1, rd15, e1, e15);
    checks++; if (l1 !== 1) begin errors++; $display("FAIL lat1_load got %0d exp 1", l1); end
    checks++; if (l15 !== 15) begin errors++; $display("FAIL lat15_load got %0d exp 15", l15); end
    checks++; if (rd1 !== 32'hCAFEF00D || e1 !== 1'b0) begin errors++; $display("FAIL lat1_data got rdata=%08h err=%0b exp cafef00d 0", rd1, e1); end
    checks++; if (rd15 !== 32'hCAFEF00D || e15 !== 1'b0) begin errors++; $display("FAIL lat15_data got rdata=%08h err=%0b exp cafef00d 0", rd15, e15); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    test_latency_builds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
